// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares one synchronous data-memory port between the pipeline MEM
//            stage (P, priority) and a loader/debug master (D), with a
//            starvation-triggered forced D burst and tagged read-data return.
// Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_WAIT    = 4,
    parameter int FORCE_BEATS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_p_valid,
    input  logic          i_p_we,
    input  logic [AW-1:0] i_p_addr,
    input  logic [DW-1:0] i_p_wdata,
    output logic          o_p_stall,
    output logic [DW-1:0] o_p_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam int BCW = $clog2(FORCE_BEATS + 1);
    localparam logic [WCW-1:0] c_max_wait  = WCW'(MAX_WAIT);
    localparam logic [BCW-1:0] c_last_beat = BCW'(FORCE_BEATS - 1);
    localparam logic [BCW-1:0] c_one_beat  = BCW'(1);

    typedef enum logic [0:0] {
        ST_P_PRI = 1'b0,
        ST_FORCE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t         r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic [BCW-1:0] r_beat_cnt;
    owner_t         r_rd_tag;

    owner_t         w_own;
    logic           w_forced;
    logic           w_d_gnt;

    // Starvation grant only applies in P_PRI; inside a burst wait_cnt is ignored.
    assign w_forced = (r_state == ST_P_PRI) && i_d_req && (r_wait_cnt == c_max_wait);

    always_comb begin
        w_own = OWN_NONE;
        if (!rst_n) begin
            w_own = OWN_NONE;
        end else if ((r_state == ST_FORCE) && i_d_req) begin
            w_own = OWN_D;
        end else if (w_forced) begin
            w_own = OWN_D;
        end else if (i_p_valid) begin
            w_own = OWN_P;
        end else if (i_d_req) begin
            w_own = OWN_D;
        end
    end

    assign w_d_gnt = (w_own == OWN_D);

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_own == OWN_P) begin
            o_mem_we    = i_p_we;
            o_mem_addr  = i_p_addr;
            o_mem_wdata = i_p_wdata;
        end else if (w_own == OWN_D) begin
            o_mem_we    = i_d_we;
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
        end
    end

    assign o_mem_en   = (w_own != OWN_NONE);
    assign o_d_gnt    = w_d_gnt;
    assign o_p_stall  = rst_n && i_p_valid && (w_own != OWN_P);

    // Memory data is broadcast; the tag decides who may consume it.
    assign o_p_rdata  = i_mem_rdata;
    assign o_d_rdata  = i_mem_rdata;
    assign o_d_rvalid = (r_rd_tag == OWN_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_P_PRI;
            r_wait_cnt <= '0;
            r_beat_cnt <= '0;
            r_rd_tag   <= OWN_NONE;
        end else begin
            if ((w_own == OWN_P) && !i_p_we) begin
                r_rd_tag <= OWN_P;
            end else if ((w_own == OWN_D) && !i_d_we) begin
                r_rd_tag <= OWN_D;
            end else begin
                r_rd_tag <= OWN_NONE;
            end

            if (i_d_req && !w_d_gnt) begin
                if (r_wait_cnt != c_max_wait) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            case (r_state)
                ST_P_PRI: begin
                    // A single-beat burst is complete on the forced grant itself.
                    if (w_forced && (FORCE_BEATS > 1)) begin
                        r_state    <= ST_FORCE;
                        r_beat_cnt <= c_one_beat;
                    end
                end
                ST_FORCE: begin
                    if (!i_d_req || (r_beat_cnt == c_last_beat)) begin
                        r_state    <= ST_P_PRI;
                        r_beat_cnt <= '0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_P_PRI;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Scoreboard bench for dmem_port_arbiter with a 1-cycle memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_p_valid = 1'b0, i_p_we = 1'b0;
    logic [31:0] i_p_addr = '0, i_p_wdata = '0;
    logic        i_d_req = 1'b0, i_d_we = 1'b0;
    logic [31:0] i_d_addr = '0, i_d_wdata = '0;
    logic        o_p_stall, o_d_gnt, o_d_rvalid, o_mem_en, o_mem_we;
    logic [31:0] o_p_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic [31:0] i_mem_rdata = '0;

    dmem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .FORCE_BEATS(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_p_valid   (i_p_valid),
        .i_p_we      (i_p_we),
        .i_p_addr    (i_p_addr),
        .i_p_wdata   (i_p_wdata),
        .o_p_stall   (o_p_stall),
        .o_p_rdata   (o_p_rdata),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .o_d_gnt     (o_d_gnt),
        .o_d_rvalid  (o_d_rvalid),
        .o_d_rdata   (o_d_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] shadow [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 32'hA000_0000 + i;
            shadow[i] = 32'hA000_0000 + i;
        end
        mem[4]    = 32'hDEAD_BEEF;
        shadow[4] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr[7:2]] <= o_mem_wdata;
            else          i_mem_rdata <= mem[o_mem_addr[7:2]];
        end
    end

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [31:0] data;
    } rsp_t;

    rsp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: samples just after each rising edge.
    initial begin
        rsp_t r;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                r = q.pop_front();
                if (r.is_d) begin
                    check_val("d_rvalid", o_d_rvalid, 1);
                    check_val("d_rdata", o_d_rdata, r.data);
                end else begin
                    check_val("p_rdata", o_p_rdata, r.data);
                    check_val("d_rvalid_on_p", o_d_rvalid, 0);
                end
            end else begin
                check_val("d_rvalid_idle", o_d_rvalid, 0);
            end
        end
    end

    // own: 0 none, 1 P, 2 D. Called at a falling edge; returns at the next one.
    task automatic drive(input logic pv, input logic pwe, input logic [31:0] pa, input logic [31:0] pwd,
                         input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                         input int own);
        logic [31:0] a, wd;
        logic        we;
        i_p_valid = pv;  i_p_we = pwe;  i_p_addr = pa;  i_p_wdata = pwd;
        i_d_req   = dr;  i_d_we = dwe;  i_d_addr = da;  i_d_wdata = dwd;
        #1;
        check_val("mem_en", o_mem_en, (own != 0));
        check_val("d_gnt", o_d_gnt, (own == 2));
        check_val("p_stall", o_p_stall, (rst_n && pv && own != 1));
        if (own != 0) begin
            a  = (own == 1) ? pa  : da;
            we = (own == 1) ? pwe : dwe;
            wd = (own == 1) ? pwd : dwd;
            check_val("mem_addr", o_mem_addr, a);
            check_val("mem_we", o_mem_we, we);
            if (we) begin
                check_val("mem_wdata", o_mem_wdata, wd);
                shadow[a[7:2]] = wd;
            end else begin
                q.push_back('{cyc: cyc + 1, is_d: (own == 2), data: shadow[a[7:2]]});
            end
        end
        if (!rst_n) q.delete();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic both(input int own);
        drive(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, own);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        // Outputs held inactive during reset regardless of requests.
        both(0);
        rst_n = 1'b1;
        idle();

        // P load, no D
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
        idle();

        // D write on idle P, then read it back
        drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h55, 2);
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0, 2);
        idle();

        // Sustained contention: 4 P, 2 forced D, repeating
        for (int i = 0; i < 12; i++) both(((i % 6) < 4) ? 1 : 2);
        idle();

        // Alternating owners back-to-back
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 32'h14, 0, 2);
        drive(1, 0, 32'h18, 0, 1, 0, 32'h1C, 0, 1);
        idle();

        // D drops after first forced beat
        for (int i = 0; i < 4; i++) both(1);
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 2);
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 1);
        idle();

        // Reset while a forced D read is in flight
        for (int i = 0; i < 4; i++) both(1);
        both(2);
        rst_n = 1'b0;
        both(0);
        both(0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) both((i < 4) ? 1 : 2);
        both(1);
        repeat (3) idle();

        check_val("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
